regfile_wr_arbiter: RTL and testbench
=====================================

Name: regfile_wr_arbiter

Overview:
- Owns the single register-file write port: produces the 5-bit select, enable and data that drive the 32-way write decoder.
- Shares the port round-robin between NUM_REQ requesters (writeback, multdiv, load return, board-state engine).
- Contains a clear sequencer that zeroes r1..r31 on command.
- Sits between the pipeline writeback sources and the register file decoder/regs.

Parameters:
- NUM_REQ, 4, number of write requesters (2..8)
- ADDR_W, 5, register select width; 2**ADDR_W registers
- DATA_W, 32, write data width

Ports:
- clock  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- req  in  NUM_REQ  per-requester write request (level)
- req_addr  in  NUM_REQ*ADDR_W  packed target register per requester; requester i uses bits [i*ADDR_W +: ADDR_W]
- req_data  in  NUM_REQ*DATA_W  packed write data per requester
- clear_start  in  1  pulse: zero the register file
- gnt  out  NUM_REQ  one-hot grant, 1-cycle pulse
- wr_en  out  1  to decoder enable
- wr_sel  out  ADDR_W  to decoder select
- wr_data  out  DATA_W  to register data inputs
- busy  out  1  high while in CLEAR
- clear_done  out  1  1-cycle pulse at end of clear

Behaviour:
- Reset (async, reset_n low): gnt=0, wr_en=0, wr_sel=0, wr_data=0, busy=0, clear_done=0; priority pointer=0; state=IDLE. Takes effect immediately, including mid-clear. Any in-progress clear is abandoned, not resumed.
- All outputs are registered. A request sampled at edge N produces gnt/wr_en/wr_sel/wr_data valid after edge N, held for exactly one cycle.
- State IDLE:
  - Among eligible requests, grant the first index at or after the pointer, wrapping modulo NUM_REQ.
  - On a grant to i: gnt[i]=1, wr_en=1, wr_sel=req_addr[i], wr_data=req_data[i], pointer<=(i+1) mod NUM_REQ.
  - No eligible request: gnt=0, wr_en=0; wr_sel and wr_data hold their last values; pointer unchanged.
- Eligibility:
  - req[i]=1, and i was not granted at the immediately preceding edge. This one-cycle mask prevents a double write while the requester drops req after seeing gnt.
  - A requester holding req continuously is therefore granted at most every other cycle.
- Requester rules:
  - Hold req, req_addr and req_data stable until gnt[i] is seen.
  - Deassert req or present new data in the cycle after gnt.
- State CLEAR:
  - Entered from IDLE when clear_start=1 at an edge. clear_start beats any simultaneous requests; those requests stay pending and are not granted.
  - Each cycle: wr_en=1, wr_data=0, wr_sel counts 1,2,…,31. That is 31 cycles; r0 is never written.
  - busy=1 for all cycles in CLEAR.
  - gnt is held at 0; req is ignored, not lost (level-held).
  - After wr_sel=31 is output, the next edge returns to IDLE with clear_done=1 for one cycle and busy=0.
  - Pending requests are arbitrated from that same edge onward, using the pointer value saved from before the clear.
  - clear_start while in CLEAR is ignored.
- Counter width: wr_sel is an ADDR_W-bit counter. Its terminal value is 2**ADDR_W-1 and it never wraps to 0.
- gnt is never more than one-hot. wr_en=1 implies either exactly one gnt bit set or busy=1.

Optional Feature:
- Macro: REG0_PROTECT_EN.
- Defined:
  - A granted request whose addr==0 still receives gnt, and the pointer still advances.
  - wr_en is forced to 0 for that cycle, so r0 stays hardwired zero.
- Undefined: address-0 writes pass through with wr_en=1. The register file is then responsible for r0.
- The clear sequencer never emits address 0 in either build.

Test Plan:
- Reset: hold reset_n=0 with req=4'b1111. All outputs stay 0. Release reset; the first grant is gnt=4'b0001 one cycle after the first edge.
- Round-robin: req=4'b1111 held constantly, distinct addr/data per requester. Grants follow 0001,0010,0100,1000,0001…; each wr_sel/wr_data matches the granted requester.
- Mask: only req[2]=1, held for 6 cycles. gnt[2] pulses on alternate cycles (3 grants); wr_en=0 in the gap cycles.
- Clear:
  - Stimulus: clear_start pulse, with req[1]=1 asserted in the same cycle.
  - Required: busy=1 for 31 cycles; wr_sel steps 1..31 with wr_data=0 and gnt=0.
  - Then clear_done pulses once, and gnt=4'b0010 follows at the same edge.
- Reset mid-clear: drop reset_n when wr_sel=10. Outputs go to 0 asynchronously; after release, state is IDLE and busy=0.
- REG0_PROTECT_EN:
  - Stimulus: req[0] with addr=0, data=32'hDEADBEEF.
  - Defined: gnt[0]=1 with wr_en=0.
  - Undefined: wr_en=1 with wr_sel=0.

Source files
------------

// File: rtl/regfile_wr_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_wr_arbiter_if
//  Description : Bundle of requester-side and register-file-side signals of
//                the register-file write arbiter. The "master" modport is the
//                side that raises requests and consumes the write port; the
//                "slave" modport is the arbiter itself.
//  Revision    : 1.0 - initial release
// ============================================================================
interface regfile_wr_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 5,
    parameter int DATA_W  = 32
);
    // Requester side
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic                      clear_start;
    logic [NUM_REQ-1:0]        gnt;

    // Register-file write port and status
    logic                      wr_en;
    logic [ADDR_W-1:0]         wr_sel;
    logic [DATA_W-1:0]         wr_data;
    logic                      busy;
    logic                      clear_done;

    modport master (
        output req,
        output req_addr,
        output req_data,
        output clear_start,
        input  gnt,
        input  wr_en,
        input  wr_sel,
        input  wr_data,
        input  busy,
        input  clear_done
    );

    modport slave (
        input  req,
        input  req_addr,
        input  req_data,
        input  clear_start,
        output gnt,
        output wr_en,
        output wr_sel,
        output wr_data,
        output busy,
        output clear_done
    );
endinterface
`default_nettype wire

// File: rtl/regfile_wr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_wr_arbiter
//  Description : Owns the single register-file write port. Shares it
//                round-robin between NUM_REQ requesters and contains a clear
//                sequencer that zeroes r1..r(2**ADDR_W-1) on command.
//                All outputs are registered.
//  Build option: define REG0_PROTECT_EN to suppress wr_en for granted writes
//                targeting address 0 (grant and pointer advance still occur).
//  Revision    : 1.0 - initial release
// ============================================================================
module regfile_wr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 5,
    parameter int DATA_W  = 32
) (
    input  wire                    clock,
    input  wire                    reset_n,
    regfile_wr_arbiter_if.slave    bus
);

    localparam int                PTR_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [ADDR_W-1:0] C_SEL_MAX = {ADDR_W{1'b1}};
    localparam logic [ADDR_W-1:0] C_SEL_ONE = ADDR_W'(1);
    localparam logic [PTR_W-1:0]  C_PTR_TOP = PTR_W'(NUM_REQ - 1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // Registered state and outputs
    // ------------------------------------------------------------------
    state_t              state_q,      state_d;
    logic [PTR_W-1:0]    ptr_q,        ptr_d;
    logic [NUM_REQ-1:0]  gnt_q,        gnt_d;
    logic                wr_en_q,      wr_en_d;
    logic [ADDR_W-1:0]   wr_sel_q,     wr_sel_d;
    logic [DATA_W-1:0]   wr_data_q,    wr_data_d;
    logic                busy_q,       busy_d;
    logic                clear_done_q, clear_done_d;

    // ------------------------------------------------------------------
    // Arbitration helpers
    // ------------------------------------------------------------------
    logic [ADDR_W-1:0]   req_addr_a [NUM_REQ];
    logic [DATA_W-1:0]   req_data_a [NUM_REQ];
    logic [NUM_REQ-1:0]  eligible;
    logic                found;
    logic [PTR_W-1:0]    grant_idx;
    int                  scan_idx;

    // Unpack the flat per-requester address/data buses into arrays.
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            req_addr_a[i] = bus.req_addr[i*ADDR_W +: ADDR_W];
            req_data_a[i] = bus.req_data[i*DATA_W +: DATA_W];
        end
    end

    // Round-robin pick: first eligible index at or after the pointer.
    // A requester granted at the previous edge is masked for one cycle so
    // it has time to drop req before it could be granted again.
    always_comb begin
        eligible  = bus.req & ~gnt_q;
        found     = 1'b0;
        grant_idx = '0;
        scan_idx  = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan_idx = int'(ptr_q) + k;
            if (scan_idx >= NUM_REQ) begin
                scan_idx = scan_idx - NUM_REQ;
            end
            if (!found && eligible[scan_idx]) begin
                found     = 1'b1;
                grant_idx = PTR_W'(scan_idx);
            end
        end
    end

    // Next-state and next-output logic for the IDLE/CLEAR controller.
    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        gnt_d        = '0;
        wr_en_d      = 1'b0;
        wr_sel_d     = wr_sel_q;
        wr_data_d    = wr_data_q;
        busy_d       = 1'b0;
        clear_done_d = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.clear_start) begin
                    // Clear beats any simultaneous request; those stay pending.
                    state_d   = ST_CLEAR;
                    busy_d    = 1'b1;
                    wr_en_d   = 1'b1;
                    wr_sel_d  = C_SEL_ONE;
                    wr_data_d = '0;
                end
            end
            ST_CLEAR: begin
                if (wr_sel_q == C_SEL_MAX) begin
                    // Last register was written; hand the port back at this
                    // same edge so pending requests are served immediately.
                    state_d      = ST_IDLE;
                    clear_done_d = 1'b1;
                end else begin
                    busy_d    = 1'b1;
                    wr_en_d   = 1'b1;
                    wr_sel_d  = wr_sel_q + C_SEL_ONE;
                    wr_data_d = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Arbitration runs whenever the next state is IDLE and no clear is
        // being started; during CLEAR req is ignored but remains pending.
        if ((state_d == ST_IDLE) && found) begin
            gnt_d[grant_idx] = 1'b1;
            wr_sel_d         = req_addr_a[grant_idx];
            wr_data_d        = req_data_a[grant_idx];
            ptr_d            = (grant_idx == C_PTR_TOP) ? '0 : grant_idx + PTR_W'(1);
`ifdef REG0_PROTECT_EN
            // r0 is hardwired zero: keep the grant but suppress the write.
            wr_en_d          = (req_addr_a[grant_idx] != '0);
`else
            wr_en_d          = 1'b1;
`endif
        end
    end

    // State and output registers; async reset abandons any clear in flight.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            ptr_q        <= '0;
            gnt_q        <= '0;
            wr_en_q      <= 1'b0;
            wr_sel_q     <= '0;
            wr_data_q    <= '0;
            busy_q       <= 1'b0;
            clear_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            gnt_q        <= gnt_d;
            wr_en_q      <= wr_en_d;
            wr_sel_q     <= wr_sel_d;
            wr_data_q    <= wr_data_d;
            busy_q       <= busy_d;
            clear_done_q <= clear_done_d;
        end
    end

    assign bus.gnt        = gnt_q;
    assign bus.wr_en      = wr_en_q;
    assign bus.wr_sel     = wr_sel_q;
    assign bus.wr_data    = wr_data_q;
    assign bus.busy       = busy_q;
    assign bus.clear_done = clear_done_q;

endmodule
`default_nettype wire

// File: tb/tb_regfile_wr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_regfile_wr_arbiter
//  Description : Directed self-checking bench for regfile_wr_arbiter
//                (NUM_REQ=4, ADDR_W=5, DATA_W=32). Honours REG0_PROTECT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_wr_arbiter;

    localparam int NUM_REQ = 4;
    localparam int ADDR_W  = 5;
    localparam int DATA_W  = 32;

    logic clock;
    logic reset_n;

    int n_checks;
    int n_errors;

    regfile_wr_arbiter_if #(
        .NUM_REQ (NUM_REQ),
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W)
    ) u_if ();

    regfile_wr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W)
    ) u_dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (u_if.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".gnt"},        64'(u_if.gnt),        64'h0);
        check({tag, ".wr_en"},      64'(u_if.wr_en),      64'h0);
        check({tag, ".wr_sel"},     64'(u_if.wr_sel),     64'h0);
        check({tag, ".wr_data"},    64'(u_if.wr_data),    64'h0);
        check({tag, ".busy"},       64'(u_if.busy),       64'h0);
        check({tag, ".clear_done"}, 64'(u_if.clear_done), 64'h0);
    endtask

    task automatic check_grant(input string tag, input logic [3:0] g,
                               input logic [4:0] sel, input logic [31:0] dat);
        check({tag, ".gnt"},     64'(u_if.gnt),     64'(g));
        check({tag, ".wr_en"},   64'(u_if.wr_en),   64'h1);
        check({tag, ".wr_sel"},  64'(u_if.wr_sel),  64'(sel));
        check({tag, ".wr_data"}, 64'(u_if.wr_data), 64'(dat));
    endtask

    // Requester addresses 4,7,10,13 and data A0000000+i
    initial begin
        n_checks = 0;
        n_errors = 0;
        reset_n  = 1'b0;
        u_if.req         = 4'b1111;
        u_if.req_addr    = {5'd13, 5'd10, 5'd7, 5'd4};
        u_if.req_data    = {32'hA000_0003, 32'hA000_0002, 32'hA000_0001, 32'hA000_0000};
        u_if.clear_start = 1'b0;

        // Reset held with all requests asserted
        tick();
        tick();
        check_all_zero("reset");
        reset_n = 1'b1;

        // Round-robin with all four requesting
        tick(); check_grant("rr0", 4'b0001, 5'd4,  32'hA000_0000);
        tick(); check_grant("rr1", 4'b0010, 5'd7,  32'hA000_0001);
        tick(); check_grant("rr2", 4'b0100, 5'd10, 32'hA000_0002);
        tick(); check_grant("rr3", 4'b1000, 5'd13, 32'hA000_0003);
        tick(); check_grant("rr4", 4'b0001, 5'd4,  32'hA000_0000);
        u_if.req = 4'b0000;

        // Idle: outputs hold sel/data, no write
        tick();
        check("idle.gnt",    64'(u_if.gnt),    64'h0);
        check("idle.wr_en",  64'(u_if.wr_en),  64'h0);
        check("idle.wr_sel", 64'(u_if.wr_sel), 64'd4);

        // Mask: requester 2 holds req for 6 cycles -> grants on alternate cycles
        u_if.req = 4'b0100;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (c % 2 == 0) begin
                check_grant($sformatf("mask%0d", c), 4'b0100, 5'd10, 32'hA000_0002);
            end else begin
                check($sformatf("mask%0d.gnt", c),    64'(u_if.gnt),    64'h0);
                check($sformatf("mask%0d.wr_en", c),  64'(u_if.wr_en),  64'h0);
                check($sformatf("mask%0d.wr_sel", c), 64'(u_if.wr_sel), 64'd10);
            end
        end
        u_if.req = 4'b0000;

        // Clear with req[1] in the same cycle; pointer is 3 at this point
        u_if.clear_start = 1'b1;
        u_if.req         = 4'b0010;
        for (int k = 1; k <= 31; k++) begin
            tick();
            u_if.clear_start = (k == 5);   // a stray start mid-clear is ignored
            check($sformatf("clr%0d.busy", k),    64'(u_if.busy),    64'h1);
            check($sformatf("clr%0d.wr_en", k),   64'(u_if.wr_en),   64'h1);
            check($sformatf("clr%0d.wr_sel", k),  64'(u_if.wr_sel),  64'(k));
            check($sformatf("clr%0d.wr_data", k), 64'(u_if.wr_data), 64'h0);
            check($sformatf("clr%0d.gnt", k),     64'(u_if.gnt),     64'h0);
        end
        u_if.clear_start = 1'b0;
        tick();
        check("clr_end.clear_done", 64'(u_if.clear_done), 64'h1);
        check("clr_end.busy",       64'(u_if.busy),       64'h0);
        check_grant("clr_end", 4'b0010, 5'd7, 32'hA000_0001);
        u_if.req = 4'b0000;
        tick();
        check("post_clr.clear_done", 64'(u_if.clear_done), 64'h0);
        check("post_clr.gnt",        64'(u_if.gnt),        64'h0);

        // Reset in the middle of a clear
        u_if.clear_start = 1'b1;
        tick();
        u_if.clear_start = 1'b0;
        for (int k = 2; k <= 10; k++) tick();
        check("midclr.wr_sel", 64'(u_if.wr_sel), 64'd10);
        check("midclr.busy",   64'(u_if.busy),   64'h1);
        reset_n = 1'b0;
        #1;
        check_all_zero("async_rst");
        tick();
        reset_n = 1'b1;
        tick();
        check("after_rst.busy",  64'(u_if.busy),  64'h0);
        check("after_rst.wr_en", 64'(u_if.wr_en), 64'h0);
        // Pointer back at 0; req[3] alone must be granted at once (IDLE)
        u_if.req = 4'b1000;
        tick();
        check_grant("after_rst", 4'b1000, 5'd13, 32'hA000_0003);
        u_if.req = 4'b0000;
        tick();

        // Write to address 0
        u_if.req_addr = {5'd13, 5'd10, 5'd7, 5'd0};
        u_if.req_data = {32'hA000_0003, 32'hA000_0002, 32'hA000_0001, 32'hDEAD_BEEF};
        u_if.req      = 4'b0001;
        tick();
        check("r0.gnt", 64'(u_if.gnt), 64'h1);
`ifdef REG0_PROTECT_EN
        check("r0.wr_en", 64'(u_if.wr_en), 64'h0);
`else
        check("r0.wr_en",   64'(u_if.wr_en),   64'h1);
        check("r0.wr_sel",  64'(u_if.wr_sel),  64'h0);
        check("r0.wr_data", 64'(u_if.wr_data), 64'hDEAD_BEEF);
`endif
        u_if.req = 4'b0000;
        tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
